// File: rtl/sound_mixer.sv
// sound_mixer: time-multiplexed per-source volume mix with saturation and an
// optional one-pole DC-blocking high-pass. One MAC per clock; one output
// sample per accepted sample strobe, N_SRC+2 cycles after the strobe.
module sound_mixer #(
    parameter int N_SRC    = 4,
    parameter int DC_SHIFT = 10
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 sample_ce,
    input  logic [16*N_SRC-1:0]  src_sound,
    input  logic [4*N_SRC-1:0]   src_vol,
    input  logic                 dc_en,
    input  logic                 overrun_clr,
    output logic [15:0]          sound,
    output logic                 sound_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FILT,
        OUT
    } state_t;

    state_t             state;
    logic signed [15:0] sh_smp [N_SRC];
    logic [3:0]         sh_vol [N_SRC];
    logic               sh_dc;
    logic signed [23:0] acc;
    logic [IW-1:0]      idx;
    logic signed [15:0] x_prev;
    logic signed [25:0] y;

    logic signed [20:0] prod;
    logic signed [25:0] acc_sh;
    logic signed [15:0] m;
    logic signed [16:0] diff;
    logic signed [25:0] d;
    logic signed [25:0] leak;
    logic signed [25:0] y_nxt;
    logic signed [25:0] y_sh;
    logic signed [15:0] r;

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            return 16'sh7fff;
        else if (v < -26'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // Datapath: current MAC product, shifted/saturated mix and the filter update
    always_comb begin
        prod   = 21'(sh_smp[idx]) * 21'($signed({1'b0, sh_vol[idx]}));
        acc_sh = $signed({{2{acc[23]}}, acc}) >>> 3;
        m      = sat16(acc_sh);
        diff   = 17'(m) - 17'(x_prev);
        d      = $signed({diff[16], diff, 8'd0});
        leak   = y >>> DC_SHIFT;
        y_nxt  = y + d - leak;
        y_sh   = y_nxt >>> 8;
        r      = sh_dc ? sat16(y_sh) : m;
    end

    // Sequencer, shadow latches, accumulator, filter state and registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sound       <= '0;
            sound_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            acc         <= '0;
            idx         <= '0;
            x_prev      <= '0;
            y           <= '0;
            sh_dc       <= 1'b0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                sh_smp[i] <= '0;
                sh_vol[i] <= '0;
            end
        end else begin
            // A strobe outside IDLE is dropped; set has priority over clear
            if (sample_ce && state != IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_ce) begin
                        for (int unsigned i = 0; i < N_SRC; i++) begin
                            sh_smp[i] <= src_sound[16*i +: 16];
                            sh_vol[i] <= src_vol[4*i +: 4];
                        end
                        sh_dc <= dc_en;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + 24'(prod);
                    if (idx == LAST_IDX)
                        state <= FILT;
                    else
                        idx <= idx + 1'b1;
                end
                FILT: begin
                    // Filter state only advances while the latched enable is set
                    if (sh_dc) begin
                        y      <= y_nxt;
                        x_prev <= m;
                    end
                    sound       <= r;
                    sound_valid <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    sound_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: table vectors, randomized mixes against an arithmetic
// reference model, and hand sequences for DC filter, overrun and reset.
module tb_sound_mixer;

    localparam int N        = 4;
    localparam int DC_SHIFT = 10;

    logic              clk_sys;
    logic              reset_n;
    logic              sample_ce;
    logic [16*N-1:0]   src_sound;
    logic [4*N-1:0]    src_vol;
    logic              dc_en;
    logic              overrun_clr;
    logic [15:0]       sound;
    logic              sound_valid;
    logic              busy;
    logic              overrun;

    int tests;
    int fails;

    // reference filter state
    longint mx;
    longint my;

    sound_mixer #(.N_SRC(N), .DC_SHIFT(DC_SHIFT)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .sample_ce   (sample_ce),
        .src_sound   (src_sound),
        .src_vol     (src_vol),
        .dc_en       (dc_en),
        .overrun_clr (overrun_clr),
        .sound       (sound),
        .sound_valid (sound_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] snd;
        logic [15:0] vol;
        bit          dc;
        int          exp;
    } vec_t;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int e);
        return {16'(e), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [15:0] pv(input int a, input int b, input int c, input int e);
        return {4'(e), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: gain = vol/8 with floor, clamp, then leaky differentiator
    function automatic int model(input logic [63:0] snd, input logic [15:0] vol, input bit dc);
        longint acc;
        longint mm;
        longint rr;
        acc = 0;
        for (int i = 0; i < N; i++)
            acc += longint'($signed(snd[16*i +: 16])) * longint'(vol[4*i +: 4]);
        mm = clamp(acc >>> 3);
        if (dc) begin
            my = my + (mm - mx) * 256 - (my >>> DC_SHIFT);
            my = (my <<< 38) >>> 38;
            mx = mm;
            rr = clamp(my >>> 8);
        end else begin
            rr = mm;
        end
        return int'(rr);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One mix: strobe on the next negedge, follow it to sound_valid
    task automatic do_mix(input logic [63:0] snd, input logic [15:0] vol, input bit dc,
                          input int exp, input string name);
        int  k;
        bit  seen;
        bit  busy_ok;
        @(negedge clk_sys);
        check({name, "_idle"}, {busy, sound_valid}, 0);
        src_sound = snd;
        src_vol   = vol;
        dc_en     = dc;
        sample_ce = 1'b1;
        seen      = 1'b0;
        busy_ok   = 1'b1;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk_sys);
            sample_ce = 1'b0;
            src_sound = {$urandom, $urandom};
            src_vol   = 16'($urandom);
            dc_en     = 1'($urandom);
            if (!busy) busy_ok = 1'b0;
            if (sound_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_latency"}, seen ? k : 0, N + 2);
        check({name, "_busy"}, busy_ok, 1);
        check({name, "_sound"}, $signed(sound), exp);
    endtask

    vec_t vecs[8];
    int   prev;
    int   e;
    int   valids;

    initial begin
        tests       = 0;
        fails       = 0;
        mx          = 0;
        my          = 0;
        reset_n     = 1'b0;
        sample_ce   = 1'b0;
        src_sound   = '0;
        src_vol     = '0;
        dc_en       = 1'b0;
        overrun_clr = 1'b0;

        vecs[0] = '{pk(1000, -200, 300, 0),        pv(8, 8, 8, 8),     1'b0, 1100};
        vecs[1] = '{pk(30000, 30000, 0, 0),        pv(15, 15, 0, 0),   1'b0, 32767};
        vecs[2] = '{pk(-32768, -32768, -32768, -32768), pv(15, 15, 15, 15), 1'b0, -32768};
        vecs[3] = '{pk(7, 1234, -999, 5),          pv(1, 0, 0, 0),     1'b0, 0};
        vecs[4] = '{pk(-7, 1234, -999, 5),         pv(1, 0, 0, 0),     1'b0, -1};
        vecs[5] = '{pk(100, 100, 100, 100),        pv(8, 4, 2, 1),     1'b0, 187};
        vecs[6] = '{pk(-1000, 0, 0, 32767),        pv(0, 0, 0, 8),     1'b0, 32767};
        vecs[7] = '{pk(-32768, 0, 0, 0),           pv(8, 0, 0, 0),     1'b0, -32768};

        // reset state
        repeat (3) @(negedge clk_sys);
        check("rst_sound", $signed(sound), 0);
        check("rst_valid", sound_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;

        // DC filter from zeroed history, back-to-back at minimum spacing
        e = model(pk(1000, 0, 0, 0), pv(8, 0, 0, 0), 1'b1);
        do_mix(pk(1000, 0, 0, 0), pv(8, 0, 0, 0), 1'b1, e, "dc_first");
        check("dc_first_1000", $signed(sound), 1000);
        prev = 1000;
        for (int i = 1; i < 8192; i++) begin
            e = model(pk(1000, 0, 0, 0), pv(8, 0, 0, 0), 1'b1);
            do_mix(pk(1000, 0, 0, 0), pv(8, 0, 0, 0), 1'b1, e, "dc_decay");
            check("dc_mono", ($signed(sound) <= prev) ? 1 : 0, 1);
            prev = int'($signed(sound));
        end
        // leak floors to zero below 2^DC_SHIFT, so the tail settles at a few LSB
        check("dc_tail", ($signed(sound) <= 3 && $signed(sound) >= -3) ? 1 : 0, 1);
        e = model(pk(0, 0, 0, 0), pv(8, 0, 0, 0), 1'b1);
        do_mix(pk(0, 0, 0, 0), pv(8, 0, 0, 0), 1'b1, e, "dc_step");
        check("dc_step_neg", ($signed(sound) < -900 && $signed(sound) > -1100) ? 1 : 0, 1);
        check("b2b_overrun", overrun, 0);

        // table vectors (bypass path)
        foreach (vecs[i]) begin
            e = model(vecs[i].snd, vecs[i].vol, vecs[i].dc);
            check("tbl_model", e, vecs[i].exp);
            do_mix(vecs[i].snd, vecs[i].vol, vecs[i].dc, vecs[i].exp, $sformatf("tbl%0d", i));
        end

        // randomized mixes, filter on and off
        for (int i = 0; i < 60; i++) begin
            logic [63:0] s;
            logic [15:0] v;
            bit          dd;
            s  = {$urandom, $urandom};
            v  = 16'($urandom);
            dd = 1'($urandom_range(0, 1));
            e  = model(s, v, dd);
            do_mix(s, v, dd, e, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        end

        // overrun: second strobe 3 cycles later is dropped
        @(negedge clk_sys);
        e = model(pk(1000, -200, 300, 0), pv(8, 8, 8, 8), 1'b0);
        src_sound = pk(1000, -200, 300, 0);
        src_vol   = pv(8, 8, 8, 8);
        dc_en     = 1'b0;
        sample_ce = 1'b1;
        valids    = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_sys);
            if (sound_valid) valids++;
            sample_ce = (k == 3);
            if (k == 3) src_sound = pk(5000, 5000, 5000, 5000);
        end
        check("ovr_valids", valids, 1);
        check("ovr_set", overrun, 1);
        check("ovr_sound", $signed(sound), e);
        overrun_clr = 1'b1;
        @(negedge clk_sys);
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // simultaneous set and clear
        sample_ce = 1'b1;
        src_sound = pk(10, 20, 30, 40);
        @(negedge clk_sys);
        sample_ce = 1'b0;
        @(negedge clk_sys);
        sample_ce   = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk_sys);
        sample_ce   = 1'b0;
        overrun_clr = 1'b0;
        check("ovr_set_wins", overrun, 1);
        repeat (8) @(negedge clk_sys);
        overrun_clr = 1'b1;
        @(negedge clk_sys);
        overrun_clr = 1'b0;
        check("ovr_clr2", overrun, 0);

        // reset mid-mix
        check("pre_rst_sound_nz", (sound != 16'd0) ? 1 : 0, 1);
        src_sound = pk(20000, 0, 0, 0);
        src_vol   = pv(8, 0, 0, 0);
        dc_en     = 1'b1;
        sample_ce = 1'b1;
        @(negedge clk_sys);
        sample_ce = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check("mid_rst_sound", $signed(sound), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", sound_valid, 0);
        valids = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_sys);
            if (sound_valid) valids++;
            if (k == 3) reset_n = 1'b1;
        end
        check("mid_rst_no_valid", valids, 0);
        mx = 0;
        my = 0;
        e  = model(pk(500, 0, 0, 0), pv(8, 0, 0, 0), 1'b1);
        do_mix(pk(500, 0, 0, 0), pv(8, 0, 0, 0), 1'b1, e, "post_rst");
        check("post_rst_500", $signed(sound), 500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
